// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    // Subtractor side
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin, one bit per clock, LSB first.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned RES_W = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               d_bit;
    logic               br_nx;
    logic               accept;
    logic               last;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Full-subtractor cell, next-state and next-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        d_bit  = a_q[0] ^ b_q[0] ^ br_q;
        br_nx  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        accept = (state_q != RUN) && bus.start;
        last   = (cnt_q == CNT_W'(WIDTH - 1));

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = RES_W'({d_bit, res_q} >> 1);
                br_d  = br_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    // Last bit: the fresh difference bit completes the result
                    diff_d  = {d_bit, res_q};
                    bout_d  = br_nx;
                    ovf_d   = br_q ^ br_nx;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the bit-serial subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic prev_done;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: busy/done exclusive, done exactly one cycle wide
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_with_done: busy=%b required 0 at %0t", bus.busy, $time);
            end
            n_checks++;
            if (prev_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_width: done high two cycles in a row at %0t", $time);
            end
        end
        prev_done = bus.done;
    end

    // Drive one start pulse; returns at the negedge after the accept edge
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        @(negedge clk);
        bus.a     = ia;
        bus.b     = ib;
        bus.bin   = ibin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
    endtask

    // Count edges after accept until done is seen; -1 on timeout
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", bus.done); end
        n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff: got %h required 00", bus.diff); end
        n_checks++; if (bus.bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b required 0", bus.bout); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", bus.ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{8'd100, 8'd5, 8'h80, 8'h7F, 8'h00};
        logic [W-1:0] tb [5] = '{8'd35, 8'd10, 8'h01, 8'hFF, 8'h00};
        logic         tbi[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] ed [5] = '{8'd65, 8'hFB, 8'h7F, 8'h80, 8'hFF};
        logic         eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int k = 0; k < 5; k++) begin
            issue(ta[k], tb[k], tbi[k]);
            n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy: got %b required 1", k, bus.busy); end
            wait_done(lat);
            n_checks++; if (lat != 8) begin n_fail++; $display("FAIL dir%0d_latency: got %0d required 8", k, lat); end
            n_checks++; if (bus.diff !== ed[k]) begin n_fail++; $display("FAIL dir%0d_diff: got %h required %h", k, bus.diff, ed[k]); end
            n_checks++; if (bus.bout !== eb[k]) begin n_fail++; $display("FAIL dir%0d_bout: got %b required %b", k, bus.bout, eb[k]); end
            n_checks++; if (bus.ovf !== eo[k]) begin n_fail++; $display("FAIL dir%0d_ovf: got %b required %b", k, bus.ovf, eo[k]); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        issue(8'd50, 8'd20, 1'b0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'd1;
                bus.b     = 8'd2;
                bus.bin   = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0;
            if (i < 8) begin
                n_checks++;
                if (bus.diff !== 8'hFF) begin n_fail++; $display("FAIL busy_hold_diff: got %h required ff", bus.diff); end
            end
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++; if (lat != 8) begin n_fail++; $display("FAIL busy_ign_latency: got %0d required 8", lat); end
        n_checks++; if (bus.diff !== 8'd30) begin n_fail++; $display("FAIL busy_ign_diff: got %h required 1e", bus.diff); end
        n_checks++; if (bus.bout !== 1'b0) begin n_fail++; $display("FAIL busy_ign_bout: got %b required 0", bus.bout); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_ign_idle: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'd200, 8'd1, 1'b0);
        wait_done(lat);
        n_checks++; if (bus.diff !== 8'd199) begin n_fail++; $display("FAIL b2b_first_diff: got %0d required 199", bus.diff); end
        bus.a     = 8'd9;
        bus.b     = 8'd3;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b required 1", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b required 0", bus.done); end
        n_checks++; if (bus.diff !== 8'd199) begin n_fail++; $display("FAIL b2b_hold_diff: got %0d required 199", bus.diff); end
        wait_done(lat);
        n_checks++; if (lat != 8) begin n_fail++; $display("FAIL b2b_latency: got %0d required 8", lat); end
        n_checks++; if (bus.diff !== 8'd6) begin n_fail++; $display("FAIL b2b_second_diff: got %0d required 6", bus.diff); end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen;
        issue(8'd77, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", bus.busy); end
        n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL abort_diff: got %h required 00", bus.diff); end
        n_checks++; if (bus.bout !== 1'b0) begin n_fail++; $display("FAIL abort_bout: got %b required 0", bus.bout); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL abort_ovf: got %b required 0", bus.ovf); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: done pulsed after abort"); end
        issue(8'd9, 8'd4, 1'b0);
        wait_done(lat);
        n_checks++; if (lat != 8) begin n_fail++; $display("FAIL post_abort_latency: got %0d required 8", lat); end
        n_checks++; if (bus.diff !== 8'd5) begin n_fail++; $display("FAIL post_abort_diff: got %0d required 5", bus.diff); end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, ed;
        logic         rbin, eb, eo;
        logic [W:0]   full;
        int lat;
        for (int k = 0; k < 24; k++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
            ed   = full[W-1:0];
            eb   = full[W];
            eo   = (ra[W-1] != rb[W-1]) && (ed[W-1] != ra[W-1]);
            issue(ra, rb, rbin);
            wait_done(lat);
            n_checks++; if (lat != 8) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d required 8", k, lat); end
            n_checks++; if (bus.diff !== ed) begin n_fail++; $display("FAIL rnd%0d_diff: a=%h b=%h bin=%b got %h required %h", k, ra, rb, rbin, bus.diff, ed); end
            n_checks++; if (bus.bout !== eb) begin n_fail++; $display("FAIL rnd%0d_bout: got %b required %b", k, bus.bout, eb); end
            n_checks++; if (bus.ovf !== eo) begin n_fail++; $display("FAIL rnd%0d_ovf: got %b required %b", k, bus.ovf, eo); end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        prev_done = 1'b0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
